slc3_mem_arbiter: RTL and testbench

- Shares the single-port SLC-3 program/data memory between two requesters: the CPU datapath (`cpu_*`) and the program loader/debug port (`ldr_*`).
- Sits between the CPU's memory interface and the memory instance.
- Serializes accesses, handles fixed read latency, and returns completion strobes.
- Uses fixed CPU priority with aging so the loader cannot be starved.

---
 rtl/slc3_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: shares the single-port SLC-3 program/data memory between the CPU
// datapath and the loader/debug port. The CPU has priority, and aging guarantees the loader a grant.
module slc3_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ready,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STRV_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [STRV_W-1:0]  starve_cnt;
    logic               cmd_we;
    logic               ldr_win;

    // The loader wins when it is alone or has already lost MAX_WAIT arbitrations in a row.
    assign ldr_win = ldr_req && (!cpu_req || starve_cnt == STRV_W'(MAX_WAIT));

    // mem_addr and mem_wdata double as the command registers, so they hold between accesses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            // NOTE: the rdata registers are ordinary flops, not a memory, so they are reset like the rest.
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            cmd_we     <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ready  <= 1'b0;
            ldr_ready  <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            // NOTE: strobes default low every cycle; the case below only raises them for one cycle.
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= 1'b0;
            ldr_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        owner     <= ldr_win;
                        mem_ce    <= 1'b1;
                        cmd_we    <= ldr_win ? ldr_we : cpu_we;
                        mem_we    <= ldr_win ? ldr_we : cpu_we;
                        mem_addr  <= ldr_win ? ldr_addr : cpu_addr;
                        mem_wdata <= ldr_win ? ldr_wdata : cpu_wdata;
                        if (ldr_win) begin
                            starve_cnt <= '0;
                        end else if (ldr_req && starve_cnt != STRV_W'(MAX_WAIT)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    lat_cnt <= LAT_W'(MEM_LAT - 1);
                    if (cmd_we) begin
                        state     <= DONE;
                        cpu_ready <= !owner;
                        ldr_ready <= owner;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        state     <= DONE;
                        cpu_ready <= !owner;
                        ldr_ready <= owner;
                        if (owner) begin
                            ldr_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb_slc3_mem_arbiter: two arbiter instances (MEM_LAT=2/MAX_WAIT=3 and MEM_LAT=1/MAX_WAIT=1) under
// random traffic, each compared cycle by cycle against a transaction-timing reference model.
module tb_slc3_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int NCYC = 4000;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(32'hC3A0 ^ (a * 32'h0457));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int    LAT = (g == 0) ? 2 : 1;
        localparam int    MW  = (g == 0) ? 3 : 1;
        localparam string PFX = (g == 0) ? "lat2 " : "lat1 ";

        logic          Reset, cpu_req, cpu_we, ldr_req, ldr_we;
        logic          cpu_ready, ldr_ready, mem_ce, mem_we, busy, owner;
        logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
        logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;

        slc3_mem_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW)
        ) u_dut (
            .Clk(Clk), .Reset(Reset),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
            .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
            .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
            .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
        );

        // Memory with exactly LAT cycles from the mem_ce cycle to valid data; garbage otherwise.
        logic [DW-1:0] mem    [16];
        logic [DW-1:0] shadow [16];
        logic [DW:0]   pipe   [LAT];
        logic [DW-1:0] junk;
        bit            filled = 1'b0;

        always @(posedge Clk) begin
            junk <= DW'($urandom);
            if (!filled) begin
                for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
                filled <= 1'b1;
            end else if (mem_ce && mem_we) begin
                mem[mem_addr[3:0]] <= mem_wdata;
            end
            pipe[0] <= {mem_ce && !mem_we, mem[mem_addr[3:0]]};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        assign mem_rdata = pipe[LAT-1][DW] ? pipe[LAT-1][DW-1:0] : junk;

        // Random requesters: sticky requests, fields that may change at any time, rare resets.
        initial begin : drive
            Reset = 1'b0;
            cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
            ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
            repeat (2) @(posedge Clk);
            for (int c = 0; c < NCYC; c++) begin
                #1;
                Reset   = ($urandom_range(149) != 0);
                cpu_req = cpu_req ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
                ldr_req = ldr_req ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
                if ($urandom_range(1) == 1) begin
                    cpu_we    = 1'($urandom_range(1));
                    cpu_addr  = AW'($urandom_range(15));
                    cpu_wdata = DW'($urandom);
                end
                if ($urandom_range(1) == 1) begin
                    ldr_we    = 1'($urandom_range(1));
                    ldr_addr  = AW'($urandom_range(15));
                    ldr_wdata = DW'($urandom);
                end
                @(posedge Clk);
            end
        end

        // Reference: a transaction granted in IDLE cycle t occupies cycles t+1 .. t+len-1,
        // with mem_ce at t+1 and ready in the last one; len is 3 for a write, LAT+3 for a read.
        initial begin : model
            bit            armed, active, m_own, m_we;
            int            k, starve, len;
            logic [AW-1:0] m_addr;
            logic [DW-1:0] m_wdata, m_cpu_rd, m_ldr_rd;
            armed = 1'b0; active = 1'b0; m_own = 1'b0; m_we = 1'b0;
            k = 0; starve = 0;
            m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ldr_rd = '0;
            for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
            forever begin
                @(negedge Clk);
                len = m_we ? 3 : LAT + 3;
                if (armed) begin
                    check({PFX, "busy"},      busy,      active);
                    check({PFX, "mem_ce"},    mem_ce,    active && k == 1);
                    check({PFX, "mem_we"},    mem_we,    active && k == 1 && m_we);
                    check({PFX, "mem_addr"},  mem_addr,  m_addr);
                    check({PFX, "mem_wdata"}, mem_wdata, m_wdata);
                    check({PFX, "owner"},     owner,     m_own);
                    check({PFX, "cpu_ready"}, cpu_ready, active && k == len - 1 && !m_own);
                    check({PFX, "ldr_ready"}, ldr_ready, active && k == len - 1 && m_own);
                    check({PFX, "cpu_rdata"}, cpu_rdata, m_cpu_rd);
                    check({PFX, "ldr_rdata"}, ldr_rdata, m_ldr_rd);
                end
                if (!Reset) begin
                    // A write caught in ISSUE by the reset still lands in this memory model.
                    if (active && k == 1 && m_we) shadow[m_addr[3:0]] = m_wdata;
                    armed = 1'b1; active = 1'b0; k = 0; starve = 0;
                    m_own = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
                    m_cpu_rd = '0; m_ldr_rd = '0;
                end else if (!active) begin
                    if (cpu_req || ldr_req) begin
                        m_own = ldr_req && (!cpu_req || starve == MW);
                        if (m_own) starve = 0;
                        else if (ldr_req) starve = (starve < MW) ? starve + 1 : MW;
                        m_we    = m_own ? ldr_we    : cpu_we;
                        m_addr  = m_own ? ldr_addr  : cpu_addr;
                        m_wdata = m_own ? ldr_wdata : cpu_wdata;
                        active  = 1'b1;
                        k       = 1;
                    end
                end else begin
                    if (k == 1 && m_we) shadow[m_addr[3:0]] = m_wdata;
                    k++;
                    if (!m_we && k == len - 1) begin
                        if (m_own) m_ldr_rd = shadow[m_addr[3:0]];
                        else       m_cpu_rd = shadow[m_addr[3:0]];
                    end
                    if (k == len) active = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (NCYC + 10) @(posedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
